jtag_shift_master: RTL and testbench
====================================

Name: jtag_shift_master

Overview:
- JTAG initiator: drives TCK/TMS/TDI toward a target TAP (the Briey debug TAP or an external one on EX_IO) and captures TDO.
- Software-side shift commands arrive on a valid/ready command channel; captured TDO returns on a valid/ready response channel.
- Sits in the io_axiClk domain. Used for on-board self-test of the debug path and for bridging debug from a soft host without a cable.

Parameters:
- CLK_DIV, 4: io_axiClk cycles per TCK half-period. Legal range is 1..255.
- MAX_BITS, 32: width of the shift vectors. This is the maximum number of bits per command.

Ports:
- io_axiClk  input  1  system clock; all logic on rising edge
- io_asyncReset  input  1  asynchronous, active-high reset
- io_cmd_valid  input  1  command present
- io_cmd_ready  output  1  command accepted when valid&ready
- io_cmd_length  input  6  number of TCK cycles; 0 = no-op; values >MAX_BITS clamp to MAX_BITS
- io_cmd_tms  input  MAX_BITS  TMS bits, LSB shifted first
- io_cmd_tdi  input  MAX_BITS  TDI bits, LSB shifted first
- io_rsp_valid  output  1  response present
- io_rsp_ready  input  1  response consumed when valid&ready
- io_rsp_tdo  output  MAX_BITS  captured TDO, bit i = sample at i-th TCK rise; unused upper bits 0
- io_jtag_tck  output  1  TCK, registered
- io_jtag_tms  output  1  TMS, registered
- io_jtag_tdi  output  1  TDI, registered
- io_jtag_tdo  input  1  TDO from target
- io_busy  output  1  state != IDLE

Behaviour:
- Reset values:
  - tck=0, tms=1 (target held in/toward Test-Logic-Reset), tdi=0.
  - cmd_ready=0 during reset, 1 in IDLE after reset.
  - rsp_valid=0, rsp_tdo=0, busy=0.
- States: IDLE, LOW, HIGH, RSP.
- IDLE: cmd_ready=1. On the accept edge (cycle 0), latch the clamped length, tms/tdi shift registers and bit counter, and clear tdo_shift.
  - length==0: go to RSP with tdo=0 and emit no TCK. rsp_valid is high in cycle 1.
  - Otherwise go to LOW. In cycle 1, tms/tdi = bit0 and tck=0.
- LOW: hold for CLK_DIV cycles, then set tck=1 and enter HIGH.
  - Without the optional feature, TDO is sampled on this same edge into tdo_shift[bit_idx].
- HIGH: hold for CLK_DIV cycles, then set tck=0.
  - If bits remain: present the next tms/tdi bit on the same edge and re-enter LOW.
  - If not: enter RSP. tms/tdi hold the last bit.
- Timing:
  - Each bit takes exactly 2*CLK_DIV cycles.
  - First TCK rise is at cycle 1+CLK_DIV.
  - rsp_valid rises at cycle 1+length*2*CLK_DIV, coincident with the final TCK fall.
- RSP: rsp_valid=1 and rsp_tdo stable until rsp_ready. On the handshake edge, go to IDLE.
  - cmd_ready stays 0 until IDLE, so there is no command overlap.
  - There is no backpressure on TCK generation; shifting never stalls.
- Between commands, tck stays 0 and tms/tdi hold their last driven values.
- Phase counter width is $clog2(CLK_DIV+1). It reloads at every phase change, with no drift across bits.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). The partial command and any pending response are discarded.
- cmd inputs are ignored outside IDLE; their changes have no effect.

Optional Feature:
- Macro: JTAG_TDO_SYNC_EN.
- When defined:
  - io_jtag_tdo passes through a 2-flop synchronizer.
  - Sampling moves to the last cycle of HIGH (the edge where tck falls), using the synchronized value.
  - Requires CLK_DIV>=3; a compile-time check errors otherwise.
  - Overall latency is unchanged.
- When undefined:
  - Raw TDO is sampled on the edge where tck rises.
  - CLK_DIV>=1 is allowed.

Test Plan:
- CLK_DIV=4: cmd length=5, tms=5'b11111, tdi=0, accept at cycle 0 -> 5 TCK pulses, rises at cycles 5,13,21,29,37; tms=1 throughout; rsp_valid at cycle 41.
- Loopback io_jtag_tdo=io_jtag_tdi, length=8, tdi=8'hA5, tms=0 -> rsp_tdo=32'h000000A5.
  - With JTAG_TDO_SYNC_EN, same result; bench also builds with CLK_DIV=3.
- length=0 -> no TCK edge; rsp_valid at cycle 1 with tdo=0. length=40 -> exactly 32 pulses.
- Hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid/rsp_tdo stable, cmd_ready=0, tck=0. Releasing rsp_ready -> IDLE next cycle, cmd_ready=1.
- Assert io_asyncReset mid-shift on bit 3 of 16 -> same cycle tck=0, tms=1, tdi=0, busy=0, rsp_valid=0. After release, a new length=2 cmd completes normally.
- Back-to-back commands with rsp_ready tied 1 -> second command accepted the cycle after response handshake; TCK low gap >= CLK_DIV between commands.

Source files
------------

// File: rtl/jtag_shift_master.sv
// jtag_shift_master
//   JTAG initiator. A command (length, TMS vector, TDI vector) is accepted on
//   the cmd channel and shifted out LSB first on TCK/TMS/TDI. The TDO bits
//   captured during the shift come back on the rsp channel.
//   Build option: define JTAG_TDO_SYNC_EN to pass TDO through a 2-flop
//   synchronizer and sample it on the TCK falling edge. This needs CLK_DIV >= 3.
//
// Parameters
//   CLK_DIV   io_axiClk cycles per TCK half-period (1..255)
//   MAX_BITS  width of the shift vectors (1..63)
//
// Ports
//   io_axiClk, io_asyncReset       clock, async active-high reset
//   io_cmd_valid/ready             command handshake
//   io_cmd_length/tms/tdi          TCK count (clamped to MAX_BITS), TMS/TDI bits
//   io_rsp_valid/ready, io_rsp_tdo response handshake, captured TDO
//   io_jtag_tck/tms/tdi            registered JTAG drive
//   io_jtag_tdo                    TDO from the target
//   io_busy                        a command is in flight
module jtag_shift_master #(
   parameter int CLK_DIV  = 4,
   parameter int MAX_BITS = 32
) (
   input  logic                io_axiClk,
   input  logic                io_asyncReset,
   input  logic                io_cmd_valid,
   output logic                io_cmd_ready,
   input  logic [5:0]          io_cmd_length,
   input  logic [MAX_BITS-1:0] io_cmd_tms,
   input  logic [MAX_BITS-1:0] io_cmd_tdi,
   output logic                io_rsp_valid,
   input  logic                io_rsp_ready,
   output logic [MAX_BITS-1:0] io_rsp_tdo,
   output logic                io_jtag_tck,
   output logic                io_jtag_tms,
   output logic                io_jtag_tdi,
   input  logic                io_jtag_tdo,
   output logic                io_busy
);

   localparam int PH_W = $clog2(CLK_DIV + 1);
   localparam logic [PH_W-1:0] PH_RLD = PH_W'(CLK_DIV - 1);

   generate
      if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
         $error("jtag_shift_master: CLK_DIV must be 1..255");
      end
      if (MAX_BITS < 1 || MAX_BITS > 63) begin : g_bad_bits
         $error("jtag_shift_master: MAX_BITS must be 1..63");
      end
`ifdef JTAG_TDO_SYNC_EN
      if (CLK_DIV < 3) begin : g_bad_sync_div
         $error("jtag_shift_master: JTAG_TDO_SYNC_EN requires CLK_DIV >= 3");
      end
`endif
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RSP} state_t;

   state_t              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [5:0]          len_q, len_d;
   logic [5:0]          bit_idx_q, bit_idx_d;
   logic [MAX_BITS-1:0] tms_sr_q, tms_sr_d;
   logic [MAX_BITS-1:0] tdi_sr_q, tdi_sr_d;
   logic [MAX_BITS-1:0] tdo_shift_q, tdo_shift_d;
   logic                tck_q, tck_d;
   logic                tms_q, tms_d;
   logic                tdi_q, tdi_d;

   logic                cmd_fire, rsp_fire, phase_done, last_bit, tdo_smp;
   logic [5:0]          len_clamp;
   logic [MAX_BITS-1:0] tdo_bit;

`ifdef JTAG_TDO_SYNC_EN
   logic tdo_meta_q, tdo_meta_d;
   logic tdo_sync_q, tdo_sync_d;
   assign tdo_meta_d = io_jtag_tdo;
   assign tdo_sync_d = tdo_meta_q;
   assign tdo_smp    = tdo_sync_q;
`else
   assign tdo_smp    = io_jtag_tdo;
`endif

   assign cmd_fire   = io_cmd_valid & io_cmd_ready;
   assign rsp_fire   = io_rsp_valid & io_rsp_ready;
   assign phase_done = (phase_q == '0);
   assign last_bit   = (bit_idx_q == len_q - 6'd1);
   assign len_clamp  = (io_cmd_length > 6'(MAX_BITS)) ? 6'(MAX_BITS) : io_cmd_length;
   // One-hot mask placing the sampled TDO at the current bit position.
   assign tdo_bit    = {{(MAX_BITS-1){1'b0}}, tdo_smp} << bit_idx_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
      if (io_asyncReset) state_q <= S_IDLE;
      else               state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_fire) state_d = (len_clamp == 6'd0) ? S_RSP : S_LOW;
         S_LOW:   if (phase_done) state_d = S_HIGH;
         S_HIGH:  if (phase_done) state_d = last_bit ? S_RSP : S_LOW;
         S_RSP:   if (rsp_fire) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      io_cmd_ready = (state_q == S_IDLE) & ~io_asyncReset;
      io_busy      = (state_q != S_IDLE);
      io_rsp_valid = (state_q == S_RSP);
      io_rsp_tdo   = (state_q == S_RSP) ? tdo_shift_q : '0;
   end

   assign io_jtag_tck = tck_q;
   assign io_jtag_tms = tms_q;
   assign io_jtag_tdi = tdi_q;

   // ---------------- datapath ----------------
   always_comb begin
      phase_d     = phase_q;
      len_d       = len_q;
      bit_idx_d   = bit_idx_q;
      tms_sr_d    = tms_sr_q;
      tdi_sr_d    = tdi_sr_q;
      tdo_shift_d = tdo_shift_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               len_d       = len_clamp;
               bit_idx_d   = 6'd0;
               phase_d     = PH_RLD;
               tdo_shift_d = '0;
               tms_sr_d    = io_cmd_tms >> 1;
               tdi_sr_d    = io_cmd_tdi >> 1;
               // A zero-length command leaves the pins untouched.
               if (len_clamp != 6'd0) begin
                  tms_d = io_cmd_tms[0];
                  tdi_d = io_cmd_tdi[0];
                  tck_d = 1'b0;
               end
            end
         end
         S_LOW: begin
            if (phase_done) begin
               tck_d   = 1'b1;
               phase_d = PH_RLD;
`ifndef JTAG_TDO_SYNC_EN
               tdo_shift_d = tdo_shift_q | tdo_bit;
`endif
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         S_HIGH: begin
            if (phase_done) begin
               tck_d   = 1'b0;
               phase_d = PH_RLD;
`ifdef JTAG_TDO_SYNC_EN
               // Synchronized TDO reflects the value from two cycles ago,
               // well inside the high phase when CLK_DIV >= 3.
               tdo_shift_d = tdo_shift_q | tdo_bit;
`endif
               if (!last_bit) begin
                  bit_idx_d = bit_idx_q + 6'd1;
                  tms_d     = tms_sr_q[0];
                  tdi_d     = tdi_sr_q[0];
                  tms_sr_d  = tms_sr_q >> 1;
                  tdi_sr_d  = tdi_sr_q >> 1;
               end
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         phase_q     <= '0;
         len_q       <= '0;
         bit_idx_q   <= '0;
         tms_sr_q    <= '0;
         tdi_sr_q    <= '0;
         tdo_shift_q <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
`ifdef JTAG_TDO_SYNC_EN
         tdo_meta_q  <= 1'b0;
         tdo_sync_q  <= 1'b0;
`endif
      end else begin
         phase_q     <= phase_d;
         len_q       <= len_d;
         bit_idx_q   <= bit_idx_d;
         tms_sr_q    <= tms_sr_d;
         tdi_sr_q    <= tdi_sr_d;
         tdo_shift_q <= tdo_shift_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
`ifdef JTAG_TDO_SYNC_EN
         tdo_meta_q  <= tdo_meta_d;
         tdo_sync_q  <= tdo_sync_d;
`endif
      end
   end

endmodule

// File: tb/tb_jtag_shift_master.sv
// tb_jtag_shift_master
//   Drives commands into jtag_shift_master with TDO looped back from TDI
//   (optionally inverted) and checks every cycle of the pin waveform and the
//   response against a per-cycle arithmetic model of the shift timing.
module tb_jtag_shift_master;
   localparam int D  = 4;
   localparam int MB = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          io_cmd_valid = 1'b0;
   logic          io_cmd_ready;
   logic [5:0]    io_cmd_length = '0;
   logic [MB-1:0] io_cmd_tms = '0;
   logic [MB-1:0] io_cmd_tdi = '0;
   logic          io_rsp_valid;
   logic          io_rsp_ready = 1'b0;
   logic [MB-1:0] io_rsp_tdo;
   logic          io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_jtag_tdo;
   logic          io_busy;
   logic          inv = 1'b0;

   assign io_jtag_tdo = io_jtag_tdi ^ inv;

   jtag_shift_master #(.CLK_DIV(D), .MAX_BITS(MB)) dut (
      .io_axiClk(clk), .io_asyncReset(rst),
      .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
      .io_cmd_length(io_cmd_length), .io_cmd_tms(io_cmd_tms), .io_cmd_tdi(io_cmd_tdi),
      .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready), .io_rsp_tdo(io_rsp_tdo),
      .io_jtag_tck(io_jtag_tck), .io_jtag_tms(io_jtag_tms), .io_jtag_tdi(io_jtag_tdi),
      .io_jtag_tdo(io_jtag_tdo), .io_busy(io_busy)
   );

   always #5 clk = ~clk;

   int   vecs = 0, errs = 0;
   logic last_tms = 1'b1, last_tdi = 1'b0;
   int   low_run = 0, gap_min = 1000;

   // {tck, tms, tdi, rsp_valid, busy, cmd_ready}
   function automatic logic [5:0] pins();
      return {io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_rsp_valid, io_busy, io_cmd_ready};
   endfunction

   // Called at a negedge; drives the command and returns after the accept edge.
   task automatic send(input int len, input logic [MB-1:0] tms, input logic [MB-1:0] tdi,
                       output int waited);
      bit ok = 0;
      io_cmd_valid  = 1'b1;
      io_cmd_length = 6'(len);
      io_cmd_tms    = tms;
      io_cmd_tdi    = tdi;
      waited = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (io_cmd_ready === 1'b1) begin
            @(posedge clk);
            ok = 1;
         end else begin
            @(negedge clk);
            waited++;
         end
      end
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL accept: cmd_ready=%b after %0d cycles, required 1", io_cmd_ready, waited);
      end
   endtask

   // Checks cycles 1.. after the accept edge. hold = extra RSP cycles with
   // rsp_ready low; tie = rsp_ready held 1; stop_at = return at that cycle.
   task automatic track(input int len, input logic [MB-1:0] tms, input logic [MB-1:0] tdi,
                        input logic inv_v, input int hold, input bit tie, input int stop_at);
      int Lc, total, pulses, first_rise, b, ph;
      logic prev;
      logic [5:0] exp_p;
      logic [63:0] m;
      logic [MB-1:0] exp_tdo;
      logic e_tms, e_tdi;
      Lc = (len > MB) ? MB : len;
      total = 1 + Lc * 2 * D;
      m = (64'd1 << Lc) - 64'd1;
      exp_tdo = (tdi ^ {MB{inv_v}}) & m[MB-1:0];
      pulses = 0; first_rise = 0; prev = 1'b0;
      e_tms = (Lc > 0) ? tms[Lc-1] : last_tms;
      e_tdi = (Lc > 0) ? tdi[Lc-1] : last_tdi;
      for (int c = 1; c <= total + hold; c++) begin
         @(negedge clk);
         // Junk on the command channel while busy must be ignored.
         io_cmd_length = 6'($urandom);
         io_cmd_tms    = $urandom;
         io_cmd_tdi    = $urandom;
         io_cmd_valid  = (c < total) ? 1'($urandom) : 1'b0;
         io_rsp_ready  = tie ? 1'b1 : (c == total + hold);
         if (c < total) begin
            b = (c - 1) / (2 * D);
            ph = (c - 1) % (2 * D);
            exp_p = {(ph >= D), tms[b], tdi[b], 1'b0, 1'b1, 1'b0};
         end else begin
            exp_p = {1'b0, e_tms, e_tdi, 1'b1, 1'b1, 1'b0};
         end
         vecs++;
         if (pins() !== exp_p) begin
            errs++;
            $display("FAIL pins len=%0d cyc=%0d: {tck,tms,tdi,rv,busy,rdy}=%b required %b",
                     len, c, pins(), exp_p);
         end
         if (c >= total) begin
            vecs++;
            if (io_rsp_tdo !== exp_tdo) begin
               errs++;
               $display("FAIL rsp_tdo len=%0d cyc=%0d: got %h required %h", len, c, io_rsp_tdo, exp_tdo);
            end
         end
         if (io_jtag_tck === 1'b1 && prev === 1'b0) begin
            pulses++;
            if (first_rise == 0) first_rise = c;
            if (low_run < gap_min) gap_min = low_run;
            low_run = 0;
         end else if (io_jtag_tck === 1'b0) begin
            low_run++;
         end
         prev = io_jtag_tck;
         if (c == stop_at) return;
      end
      @(negedge clk);
      io_rsp_ready = tie;
      low_run++;
      vecs++;
      if (pins() !== {1'b0, e_tms, e_tdi, 3'b001}) begin
         errs++;
         $display("FAIL idle len=%0d: {tck,tms,tdi,rv,busy,rdy}=%b required %b",
                  len, pins(), {1'b0, e_tms, e_tdi, 3'b001});
      end
      vecs++;
      if (pulses != Lc) begin
         errs++;
         $display("FAIL pulses len=%0d: got %0d required %0d", len, pulses, Lc);
      end
      if (Lc > 0) begin
         vecs++;
         if (first_rise != 1 + D) begin
            errs++;
            $display("FAIL first_rise len=%0d: cycle %0d required %0d", len, first_rise, 1 + D);
         end
      end
      last_tms = e_tms;
      last_tdi = e_tdi;
   endtask

   task automatic run(input int len, input logic [MB-1:0] tms, input logic [MB-1:0] tdi,
                      input logic inv_v, input int hold);
      int w;
      inv = inv_v;
      send(len, tms, tdi, w);
      track(len, tms, tdi, inv_v, hold, 1'b0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vecs++;
      if ({pins(), io_rsp_tdo} !== {6'b010000, {MB{1'b0}}}) begin
         errs++;
         $display("FAIL reset: pins=%b tdo=%h required 010000 / 0", pins(), io_rsp_tdo);
      end
      rst = 1'b0;
      #1;
      vecs++;
      if (pins() !== 6'b010001) begin
         errs++;
         $display("FAIL reset_release: pins=%b required 010001", pins());
      end
      @(negedge clk);
   endtask

   task automatic test_basic();   run(5, 32'h1f, 32'h0, 1'b0, 0);        endtask
   task automatic test_loopback(); run(8, 32'h0, 32'hA5, 1'b0, 0);       endtask
   task automatic test_zero_len(); run(0, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 0); endtask
   task automatic test_clamp();   run(40, 32'h1234_5678, 32'h9abc_def0, 1'b1, 0); endtask
   task automatic test_hold();    run(6, 32'h2a, 32'h15, 1'b1, 20);      endtask

   task automatic test_mid_reset();
      int w;
      logic [MB-1:0] tms, tdi;
      tms = $urandom & ~32'h8;
      tdi = $urandom | 32'h8;
      inv = 1'b0;
      send(16, tms, tdi, w);
      track(16, tms, tdi, 1'b0, 0, 1'b0, 1 + 7 * D);   // first high cycle of bit 3
      rst = 1'b1;
      #1;
      vecs++;
      if ({pins(), io_rsp_tdo} !== {6'b010000, {MB{1'b0}}}) begin
         errs++;
         $display("FAIL mid_reset: pins=%b tdo=%h required 010000 / 0", pins(), io_rsp_tdo);
      end
      @(negedge clk);
      rst = 1'b0;
      last_tms = 1'b1;
      last_tdi = 1'b0;
      io_cmd_valid = 1'b0;
      @(negedge clk);
      run(2, 32'h2, 32'h1, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      int w;
      io_rsp_ready = 1'b1;
      inv = 1'b0;
      send(3, 32'h5, 32'h3, w);
      track(3, 32'h5, 32'h3, 1'b0, 0, 1'b1, 0);
      gap_min = 1000;
      send(4, 32'ha, 32'hc, w);
      vecs++;
      if (w != 0) begin
         errs++;
         $display("FAIL b2b_accept: waited %0d cycles, required 0", w);
      end
      track(4, 32'ha, 32'hc, 1'b0, 0, 1'b1, 0);
      vecs++;
      if (gap_min < D) begin
         errs++;
         $display("FAIL b2b_gap: tck low run %0d, required >= %0d", gap_min, D);
      end
      io_rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         run($urandom_range(0, 63), $urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loopback();
      test_zero_len();
      test_clamp();
      test_hold();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
